// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one ALU between two requesters (0: core execute, 1: coprocessor or
// debug). A request is granted only while the block is idle. The accepted
// op and operands are held steady on the ALU inputs until the ALU reports
// not-busy. The result and flags are then parked in a single response slot
// that is tagged with the requester id. A watchdog aborts any op that keeps
// the ALU busy for too long.
//
// Parameters
//   PRIO_FIXED : 0 = round-robin when both requesters are valid,
//                1 = requester 0 always wins.
//   WAIT_MAX   : number of consecutive busy cycles in WAIT after which the op
//                is aborted with an error response.
//
// Ports
//   I_clk, I_reset        clock; synchronous active-high reset
//   I_flush               abort the in-flight op and drop any pending response
//   I_req_valid[1:0]      per-requester request valid
//   O_req_ready[1:0]      per-requester accept (one-hot or zero)
//   I_req{0,1}_aluop/s1/s2  per-requester op and operands
//   O_rsp_valid/I_rsp_ready response handshake
//   O_rsp_id/data/flags/err response id, result, {lt,ltu,eq}, timeout marker
//   O_alu_en/O_alu_reset  ALU start strobe / ALU reset
//   O_alu_aluop/s1/s2     ALU op and operands
//   I_alu_busy/data/flags ALU status, result and {lt,ltu,eq}
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int PRIO_FIXED = 0,
  parameter int WAIT_MAX   = 40
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_flush,
  input  logic [1:0]  I_req_valid,
  output logic [1:0]  O_req_ready,
  input  logic [4:0]  I_req0_aluop,
  input  logic [31:0] I_req0_s1,
  input  logic [31:0] I_req0_s2,
  input  logic [4:0]  I_req1_aluop,
  input  logic [31:0] I_req1_s1,
  input  logic [31:0] I_req1_s2,
  output logic        O_rsp_valid,
  input  logic        I_rsp_ready,
  output logic        O_rsp_id,
  output logic [31:0] O_rsp_data,
  output logic [2:0]  O_rsp_flags,
  output logic        O_rsp_err,
  output logic        O_alu_en,
  output logic        O_alu_reset,
  output logic [4:0]  O_alu_aluop,
  output logic [31:0] O_alu_s1,
  output logic [31:0] O_alu_s2,
  input  logic        I_alu_busy,
  input  logic [31:0] I_alu_data,
  input  logic [2:0]  I_alu_flags
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] s1_q, s1_d;
  logic [31:0] s2_q, s2_d;
  logic        id_q, id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [2:0]  rsp_flags_q, rsp_flags_d;
  logic        rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic        alu_rst_pulse_q, alu_rst_pulse_d;

  logic [1:0]  grant;
  logic        accept;
  logic        drive_alu;

  // ---------------------------------------------------------------------------
  // Grant: only offered in IDLE, and never in a flush or reset cycle, so a
  // request can never be accepted on the same edge that is tearing state down.
  // With both valid in round-robin mode the requester that did not win last
  // time goes first; last_grant resets to 1 so requester 0 wins the first tie.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant = 2'b00;
    if (state_q == S_IDLE && !I_flush && !I_reset) begin
      unique case (I_req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11: begin
          if (PRIO_FIXED != 0 || last_grant_q) begin
            grant = 2'b01;
          end else begin
            grant = 2'b10;
          end
        end
        default: grant = 2'b00;
      endcase
    end
  end

  assign accept = grant[0] | grant[1];

  // ---------------------------------------------------------------------------
  // Next-state and datapath capture
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    op_d            = op_q;
    s1_d            = s1_q;
    s2_d            = s2_q;
    id_d            = id_q;
    rsp_data_d      = rsp_data_q;
    rsp_flags_d     = rsp_flags_q;
    rsp_err_d       = rsp_err_q;
    wait_cnt_d      = wait_cnt_q;
    alu_rst_pulse_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d         = grant[1] ? I_req1_aluop : I_req0_aluop;
          s1_d         = grant[1] ? I_req1_s1    : I_req0_s1;
          s2_d         = grant[1] ? I_req1_s2    : I_req0_s2;
          id_d         = grant[1];
          last_grant_d = grant[1];
          state_d      = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // The ALU start strobe is high for exactly this one cycle.
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (!I_alu_busy) begin
          rsp_data_d  = I_alu_data;
          rsp_flags_d = I_alu_flags;
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end else if (wait_cnt_q == CNT_W'(WAIT_MAX - 1)) begin
          // This is the WAIT_MAX-th consecutive busy cycle: give up, reset
          // the ALU next cycle and return an error response with zeroed data.
          rsp_data_d      = '0;
          rsp_flags_d     = '0;
          rsp_err_d       = 1'b1;
          alu_rst_pulse_d = 1'b1;
          state_d         = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        // Going back to IDLE first means no request is accepted in the cycle
        // the response is consumed.
        if (I_rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Flush overrides everything except reset: drop the latched request and
    // any parked response, and reset the ALU for one cycle.
    if (I_flush) begin
      state_d         = S_IDLE;
      op_d            = '0;
      s1_d            = '0;
      s2_d            = '0;
      id_d            = 1'b0;
      rsp_data_d      = '0;
      rsp_flags_d     = '0;
      rsp_err_d       = 1'b0;
      wait_cnt_d      = '0;
      alu_rst_pulse_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q         <= S_IDLE;
      last_grant_q    <= 1'b1;
      op_q            <= '0;
      s1_q            <= '0;
      s2_q            <= '0;
      id_q            <= 1'b0;
      rsp_data_q      <= '0;
      rsp_flags_q     <= '0;
      rsp_err_q       <= 1'b0;
      wait_cnt_q      <= '0;
      alu_rst_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      op_q            <= op_d;
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      id_q            <= id_d;
      rsp_data_q      <= rsp_data_d;
      rsp_flags_q     <= rsp_flags_d;
      rsp_err_q       <= rsp_err_d;
      wait_cnt_q      <= wait_cnt_d;
      alu_rst_pulse_q <= alu_rst_pulse_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Everything except O_alu_reset is forced low while reset is held,
  // and the ALU operand bus is zero outside ISSUE/WAIT.
  // ---------------------------------------------------------------------------
  assign drive_alu = !I_reset && (state_q == S_ISSUE || state_q == S_WAIT);

  assign O_req_ready = grant;

  // The ALU is not started in a flush cycle; the op is being abandoned.
  assign O_alu_en    = !I_reset && !I_flush && (state_q == S_ISSUE);
  assign O_alu_reset = I_reset | alu_rst_pulse_q;
  assign O_alu_aluop = drive_alu ? op_q : '0;
  assign O_alu_s1    = drive_alu ? s1_q : '0;
  assign O_alu_s2    = drive_alu ? s2_q : '0;

  assign O_rsp_valid = !I_reset && (state_q == S_RESP);
  assign O_rsp_id    = O_rsp_valid ? id_q        : 1'b0;
  assign O_rsp_data  = O_rsp_valid ? rsp_data_q  : '0;
  assign O_rsp_flags = O_rsp_valid ? rsp_flags_q : '0;
  assign O_rsp_err   = O_rsp_valid ? rsp_err_q   : 1'b0;

endmodule
